// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Synchronises the serial line, confirms the
// start bit at its centre, samples eight data bits and the stop bit at
// their centres, and reports either a good byte or a framing error.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Busy
);

    // Counter just wide enough to hold CLKS_PER_BIT-1, so it never wraps mid-bit.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP,
        S_WAIT_HIGH
    } state_e;

    state_e        state_q,   state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    byte_q,    byte_d;
    logic          dv_q,      dv_d;
    logic          ferr_q,    ferr_d;
    logic          meta_q,    meta_d;
    logic          rx_s_q,    rx_s_d;

    // Two-flop synchroniser chain for the asynchronous pin.
    always_comb begin
        meta_d = i_RX_Serial;
        rx_s_d = meta_q;
    end

    // Synchroniser registers.
    always_ff @(posedge i_Clock) begin
        // NOTE: both stages preset to 1 (the idle level) so leaving reset never looks like a start bit.
        if (i_Reset) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            meta_q <= meta_d;
            rx_s_q <= rx_s_d;
        end
    end

    // Next-state and datapath logic for the receive FSM.
    always_comb begin
        // NOTE: every variable gets a default first; strobes therefore fall back to 0 and no latch is inferred.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            S_WAIT_HIGH: begin
                // A held-low break must release before another frame is accepted.
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Frame_Err = ferr_q;
    assign o_RX_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into a fast (16 clk/bit) and a default
// (434 clk/bit) receiver and compares what comes out against the bytes sent.
module tb_uart_rx;

    localparam int FAST = 16;
    localparam int HALF16 = (FAST - 1) / 2;
    localparam int LAT_LO = 9 * FAST + HALF16 + 2;
    localparam int LAT_HI = 9 * FAST + HALF16 + 5;

    logic       clk;
    logic       rst;
    logic       rx16, rx434;
    logic       dv16, ferr16, busy16;
    logic [7:0] byte16;
    logic       dv434, ferr434, busy434;
    logic [7:0] byte434;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Monitor state.
    logic [7:0] got16[$];
    logic [7:0] got434[$];
    int ferr_cnt16  = 0;
    int ferr_cnt434 = 0;
    int both_cnt    = 0;
    int busy_cnt16  = 0;
    int dv_cycle16  = 0;

    // Reference model: the bytes a correct receiver must deliver, in order.
    logic [7:0] exp16[$];
    logic [7:0] exp434[$];

    uart_rx #(.CLKS_PER_BIT(FAST)) dut16 (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_RX_Serial   (rx16),
        .o_RX_DV       (dv16),
        .o_RX_Byte     (byte16),
        .o_RX_Frame_Err(ferr16),
        .o_RX_Busy     (busy16)
    );

    uart_rx dut434 (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_RX_Serial   (rx434),
        .o_RX_DV       (dv434),
        .o_RX_Byte     (byte434),
        .o_RX_Frame_Err(ferr434),
        .o_RX_Busy     (busy434)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dv16) begin
            got16.push_back(byte16);
            dv_cycle16 = cycle;
        end
        if (dv434) got434.push_back(byte434);
        if (ferr16) ferr_cnt16++;
        if (ferr434) ferr_cnt434++;
        if ((dv16 && ferr16) || (dv434 && ferr434)) both_cnt++;
        if (busy16) busy_cnt16++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole received stream must equal the model's stream.
    task automatic check_stream16(input string tag);
        int n;
        check({tag, "_count16"}, got16.size(), exp16.size());
        n = (got16.size() < exp16.size()) ? got16.size() : exp16.size();
        for (int i = 0; i < n; i++) check({tag, "_byte16"}, got16[i], exp16[i]);
    endtask

    task automatic check_stream434(input string tag);
        int n;
        check({tag, "_count434"}, got434.size(), exp434.size());
        n = (got434.size() < exp434.size()) ? got434.size() : exp434.size();
        for (int i = 0; i < n; i++) check({tag, "_byte434"}, got434[i], exp434[i]);
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) rx16 = v;
        else rx434 = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: start bit, data LSB first, stop bit; each bit lasts `period` clocks.
    task automatic send(input int line, input logic [7:0] b, input int period, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive(line, 1'b0);
            else if (i == 9) drive(line, stop_bit);
            else drive(line, (b >> (i - 1)) & 8'h01);
            wait_cycles(period);
        end
        if (stop_bit) begin
            if (line == 0) exp16.push_back(b);
            else exp434.push_back(b);
        end
    endtask

    initial begin
        int fall_cycle;
        int busy_before;
        int ferr_before;
        logic [7:0] prior;
        logic [7:0] rnd;

        rst   = 1'b1;
        rx16  = 1'b1;
        rx434 = 1'b1;
        wait_cycles(4);
        check("reset_dv", dv16, 1'b0);
        check("reset_byte", byte16, 8'h00);
        check("reset_ferr", ferr16, 1'b0);
        check("reset_busy", busy16, 1'b0);
        check("reset_byte434", byte434, 8'h00);
        rst = 1'b0;
        wait_cycles(5);

        // 1: single good frame, latency window.
        fall_cycle = cycle;
        send(0, 8'hA5, FAST, 1'b1);
        wait_cycles(20);
        check_stream16("t1");
        check("t1_ferr", ferr_cnt16, 0);
        check("t1_latency_in_window",
              ((dv_cycle16 - fall_cycle) >= LAT_LO) && ((dv_cycle16 - fall_cycle) <= LAT_HI), 1'b1);

        // 2: short low glitch is rejected, then a good frame.
        busy_before = busy_cnt16;
        rx16 = 1'b0;
        wait_cycles(5);
        rx16 = 1'b1;
        wait_cycles(30);
        check("t2_busy_brief",
              ((busy_cnt16 - busy_before) >= 1) && ((busy_cnt16 - busy_before) <= 12), 1'b1);
        check("t2_idle", busy16, 1'b0);
        check("t2_ferr", ferr_cnt16, 0);
        check_stream16("t2_glitch");
        send(0, 8'h3C, FAST, 1'b1);
        wait_cycles(20);
        check_stream16("t2");

        // 3: framing error followed by a held-low break.
        prior = exp16[exp16.size() - 1];
        ferr_before = ferr_cnt16;
        send(0, 8'h55, FAST, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_cycles(20);
            check("t3_byte_held", byte16, prior);
        end
        check("t3_one_ferr", ferr_cnt16 - ferr_before, 1);
        check_stream16("t3_break");
        rx16 = 1'b1;
        wait_cycles(40);
        check("t3_idle", busy16, 1'b0);
        send(0, 8'h81, FAST, 1'b1);
        wait_cycles(20);
        check_stream16("t3");
        check("t3_ferr_total", ferr_cnt16 - ferr_before, 1);

        // 4: back-to-back frames, no idle gap.
        send(0, 8'h00, FAST, 1'b1);
        send(0, 8'hFF, FAST, 1'b1);
        send(0, 8'h01, FAST, 1'b1);
        wait_cycles(20);
        check_stream16("t4");

        // Random bytes with random idle gaps (including none).
        for (int k = 0; k < 6; k++) begin
            rnd = 8'($urandom);
            send(0, rnd, FAST, 1'b1);
            wait_cycles($urandom_range(0, 20));
        end
        wait_cycles(20);
        check_stream16("rand");

        // 5: reset during data bit 4 of 0xF0 aborts the frame.
        rx16 = 1'b0;
        wait_cycles(5 * FAST);
        rx16 = 1'b1;
        wait_cycles(8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_dv", dv16, 1'b0);
        check("t5_byte", byte16, 8'h00);
        check("t5_ferr", ferr16, 1'b0);
        check("t5_busy", busy16, 1'b0);
        wait_cycles(4 * FAST);
        check_stream16("t5_abort");
        send(0, 8'h0F, FAST, 1'b1);
        wait_cycles(20);
        check_stream16("t5");

        // 6: default rate with the transmitter 3% slow and 3% fast.
        send(1, 8'h7E, 421, 1'b1);
        wait_cycles(500);
        send(1, 8'h7E, 447, 1'b1);
        wait_cycles(500);
        check_stream434("t6");
        check("t6_ferr", ferr_cnt434, 0);

        check("strobe_exclusive", both_cnt, 0);
        check("ferr16_total", ferr_cnt16, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Receive-side counterpart of the team's UART transmitter: same bit timing, same CLKS_PER_BIT parameter.
- Synchronises the asynchronous serial input, detects the start bit, and samples each bit at its centre. Delivers each received byte with a one-cycle valid strobe.
- Flags framing errors. Sits between the board RX pin and the command parser.

Parameters:
- CLKS_PER_BIT, 434, system clock cycles per UART bit (50 MHz / 115200). Legal range 4..65535.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_RX_Serial  in  1  asynchronous serial line; idles high.
- o_RX_DV  out  1  one-cycle strobe: o_RX_Byte holds a valid new byte.
- o_RX_Byte  out  8  last good received byte, LSB received first. Holds its value between strobes.
- o_RX_Frame_Err  out  1  one-cycle strobe: stop bit sampled low.
- o_RX_Busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: while i_Reset=1 at a clock edge:
  - FSM goes to IDLE. Bit counter and clock counter clear to 0.
  - Both synchroniser flops preset to 1.
  - o_RX_DV=0, o_RX_Frame_Err=0, o_RX_Busy=0, o_RX_Byte=8'h00.
  - Reset has priority over every other event and aborts any frame in progress. No strobe is emitted for an aborted frame.
- Synchroniser: i_RX_Serial passes through two flops; only the second flop output (rx_s) is used internally.
- Clock counter width: wide enough for CLKS_PER_BIT-1 (at least 9 bits at the default). It must never wrap within a bit period.
- States: IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH.
- IDLE:
  - Counters held at 0.
  - rx_s=0 -> START.
- START:
  - Count up to HALF = (CLKS_PER_BIT-1)/2, integer division.
  - At count==HALF: if rx_s=0, clear the counter and go to DATA (the start bit is confirmed, and the sampling point is now mid-bit).
  - If rx_s=1 at that sample: glitch. Return to IDLE with no strobe.
- DATA:
  - Count up to CLKS_PER_BIT-1. At that count, shift rx_s into bit[index], clear the counter and increment the index.
  - After index 7 is sampled, clear the index and go to STOP.
- STOP:
  - Count up to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s=1: load o_RX_Byte from the shift register, pulse o_RX_DV for exactly one cycle, go to CLEANUP.
  - rx_s=0: pulse o_RX_Frame_Err for one cycle. o_RX_Byte is unchanged and there is no DV. Go to WAIT_HIGH.
- CLEANUP: one cycle, then IDLE. A new start bit can be detected from the next cycle.
- WAIT_HIGH: remain here until rx_s=1, then go to IDLE. A held-low break therefore produces exactly one frame error and no spurious bytes.
- Strobe exclusivity: o_RX_DV and o_RX_Frame_Err are never high in the same cycle.
- o_RX_Busy deasserts in the cycle the FSM enters IDLE.
- Latency: o_RX_DV rises between 9*CLKS_PER_BIT+HALF+2 and 9*CLKS_PER_BIT+HALF+5 cycles after the falling edge at the pin.
- Back-to-back frames: the next start bit may begin immediately after one stop-bit period. No extra idle time is required.
- Tolerance: correct reception with a transmitter baud error of up to ±3%.

Test Plan:
1. CLKS_PER_BIT=16; send 0xA5 with a good stop bit -> exactly one o_RX_DV pulse, o_RX_Byte=8'hA5; DV rises within the latency window (9*16+7+2..+5); o_RX_Frame_Err stays 0.
2. CLKS_PER_BIT=16; line driven low for 5 cycles then high -> no DV, no Frame_Err; o_RX_Busy high only briefly; FSM back in IDLE. A following 0x3C frame is received correctly.
3. CLKS_PER_BIT=16; frame 0x55 with the stop bit low, then line held low for 80 cycles, then high, then frame 0x81 -> one Frame_Err pulse; o_RX_Byte stays at its prior value during the low period; then DV with 0x81.
4. CLKS_PER_BIT=16; frames 0x00, 0xFF, 0x01 sent back-to-back with no idle gap -> three DV pulses carrying 0x00, 0xFF, 0x01 in order.
5. CLKS_PER_BIT=16; assert i_Reset for 1 cycle during data bit 4 of 0xF0, then send 0x0F -> no strobe for the aborted frame; all outputs 0 after reset; DV with 0x0F.
6. Default CLKS_PER_BIT=434; send 0x7E at bit periods of 421 and 447 cycles (±3%) -> DV with 0x7E in both cases; no Frame_Err.
